// File: rtl/ddr_pkg.sv
// Shared types and default timing constants for the DRAM-side DLL lock tracker.
// The defaults are also used by the controller-side timing checks.
package ddr_pkg;

  typedef enum logic [2:0] {
    RESET        = 3'd0,
    STABLE_WAIT  = 3'd1,
    UNLOCKED     = 3'd2,
    LOCKING      = 3'd3,
    LOCKED       = 3'd4,
    DLL_OFF      = 3'd5,
    SELF_REFRESH = 3'd6
  } dll_state_e;

  localparam int DEF_STABLE_CYC = 10;
  localparam int DEF_TDLLK      = 768;
  localparam int DEF_SR_MIN_CYC = 5;
  localparam int DEF_CNT_W      = 11;

endpackage

// File: rtl/ddr_cyc_cnt.sv
// Clear/enable up-counter with a terminal-count compare.
// Clear wins over enable; at_term is a pure compare of the current count.
module ddr_cyc_cnt
  import ddr_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  // Count register: synchronous reset and clear, increment when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/ddr_dram_dll_lock.sv
// DRAM-side DLL lock tracker clocked by CK_t.
// Qualifies the clock after reset, times tDLLK after each DLL reset, and
// flags READ/WRITE issued while the DLL is not usable (sticky until reset).
// Optional feature macro: DLL_SR_RELOCK_EN (self-refresh entry on a run of
// cke-low cycles while locked, relock on cke high).
module ddr_dram_dll_lock
  import ddr_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int TDLLK      = DEF_TDLLK,
  parameter int SR_MIN_CYC = DEF_SR_MIN_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             cke,
  input  logic             dll_en,
  input  logic             dll_rst,
  input  logic             rw_cmd,
  output logic             clk_stable,
  output logic             dll_locked,
  output logic [CNT_W-1:0] lock_cnt,
  output logic             early_access_err,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TERM   = CNT_W'(TDLLK - 1);

  dll_state_e       st_q;
  dll_state_e       st_d;
  logic             ph_clr;
  logic             ph_en;
  logic             ph_hit;
  logic [CNT_W-1:0] ph_term;
  logic [CNT_W-1:0] ph_cnt;
  logic             sr_hit;

  // The phase counter is shared by clock qualification and DLL locking;
  // only the terminal value differs between the two phases.
  assign ph_term = (st_q == STABLE_WAIT) ? STABLE_TERM : LOCK_TERM;

  ddr_cyc_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk     (CK_t),
    .rst_n   (reset_n),
    .clr     (ph_clr),
    .en      (ph_en),
    .term    (ph_term),
    .cnt     (ph_cnt),
    .at_term (ph_hit)
  );

`ifdef DLL_SR_RELOCK_EN
  localparam logic [CNT_W-1:0] SR_TERM = CNT_W'(SR_MIN_CYC - 1);

  logic [CNT_W-1:0] cke_low_cnt;
  logic             cke_at_term;
  logic             cke_clr;
  logic             cke_en;

  // Only cke-low runs observed while LOCKED count toward self-refresh entry.
  assign cke_clr = cke || (st_q != LOCKED);
  assign cke_en  = !cke && (st_q == LOCKED);

  ddr_cyc_cnt #(.W(CNT_W)) u_cke_low_cnt (
    .clk     (CK_t),
    .rst_n   (reset_n),
    .clr     (cke_clr),
    .en      (cke_en),
    .term    (SR_TERM),
    .cnt     (cke_low_cnt),
    .at_term (cke_at_term)
  );

  // This edge is the SR_MIN_CYC-th consecutive cke-low edge.
  assign sr_hit = cke_at_term && !cke;
`else
  assign sr_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      st_q <= RESET;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state and phase-counter control; priority is !dll_en > dll_rst > terminal.
  always_comb begin
    st_d   = st_q;
    ph_clr = 1'b1;
    ph_en  = 1'b0;
    unique case (st_q)
      RESET: begin
        st_d = STABLE_WAIT;
      end
      STABLE_WAIT: begin
        if (ph_hit) begin
          st_d = UNLOCKED;
        end else begin
          ph_clr = 1'b0;
          ph_en  = 1'b1;
        end
      end
      UNLOCKED: begin
        if (!dll_en) begin
          st_d = DLL_OFF;
        end else if (dll_rst) begin
          st_d = LOCKING;
        end
      end
      LOCKING: begin
        if (!dll_en) begin
          st_d = DLL_OFF;
        end else if (dll_rst) begin
          st_d = LOCKING;
        end else if (ph_hit) begin
          st_d = LOCKED;
        end else begin
          ph_clr = 1'b0;
          ph_en  = 1'b1;
        end
      end
      LOCKED: begin
        if (!dll_en) begin
          st_d = DLL_OFF;
        end else if (dll_rst) begin
          st_d = LOCKING;
        end else if (sr_hit) begin
          st_d = SELF_REFRESH;
        end
      end
      DLL_OFF: begin
        if (dll_en) begin
          st_d = dll_rst ? LOCKING : UNLOCKED;
        end
      end
      SELF_REFRESH: begin
        if (!dll_en) begin
          st_d = DLL_OFF;
        end else if (cke) begin
          st_d = LOCKING;
        end
      end
      default: begin
        st_d = RESET;
      end
    endcase
  end

  // Sticky flags: clock qualification and access-before-lock violation.
  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      clk_stable       <= 1'b0;
      early_access_err <= 1'b0;
    end else begin
      if (st_q == STABLE_WAIT && ph_hit) begin
        clk_stable <= 1'b1;
      end
      if (rw_cmd && cke && st_q != LOCKED && st_q != DLL_OFF) begin
        early_access_err <= 1'b1;
      end
    end
  end

  // Outputs decoded directly from registered state and count.
  always_comb begin
    dll_locked = (st_q == LOCKED);
    state      = st_q;
    lock_cnt   = ph_cnt;
  end

endmodule

// File: tb/tb_ddr_dram_dll_lock.sv
// Directed testbench for ddr_dram_dll_lock.
// Edge numbering: edge 0 is the first CK_t rise that samples reset_n high.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ddr_dram_dll_lock;
  import ddr_pkg::*;

  localparam int CNT_W = 11;

  logic             CK_t;
  logic             reset_n;
  logic             cke;
  logic             dll_en;
  logic             dll_rst;
  logic             rw_cmd;
  logic             clk_stable;
  logic             dll_locked;
  logic [CNT_W-1:0] lock_cnt;
  logic             early_access_err;
  logic [2:0]       state;

  int n_checks;
  int n_errors;
  int edge_n;

  ddr_dram_dll_lock dut (
    .CK_t             (CK_t),
    .reset_n          (reset_n),
    .cke              (cke),
    .dll_en           (dll_en),
    .dll_rst          (dll_rst),
    .rw_cmd           (rw_cmd),
    .clk_stable       (clk_stable),
    .dll_locked       (dll_locked),
    .lock_cnt         (lock_cnt),
    .early_access_err (early_access_err),
    .state            (state)
  );

  // Clock
  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
    edge_n++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Pulse dll_rst so that it is sampled at edge e.
  task automatic rst_pulse_at(input int e);
    run_to(e - 1);
    dll_rst = 1'b1;
    tick();
    dll_rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'(RESET));
    check({tag, "_cnt"}, 32'(lock_cnt), 32'd0);
    check({tag, "_stable"}, 32'(clk_stable), 32'd0);
    check({tag, "_locked"}, 32'(dll_locked), 32'd0);
    check({tag, "_err"}, 32'(early_access_err), 32'd0);
  endtask

  // Hold reset, check the reset state, then release so the next edge is edge 0.
  task automatic do_reset();
    reset_n = 1'b0;
    tick_n(2);
    check_all_zero("reset");
    reset_n = 1'b1;
    edge_n  = -1;
    tick();
    check("e0_state", 32'(state), 32'(STABLE_WAIT));
    check("e0_cnt", 32'(lock_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    edge_n   = 0;
    reset_n  = 1'b0;
    cke      = 1'b1;
    dll_en   = 1'b1;
    dll_rst  = 1'b0;
    rw_cmd   = 1'b0;

    // ---- Scenario 1: qualification, lock with a restart, DLL-off paths ----
    do_reset();
    run_to(9);
    check("sw_cnt9", 32'(lock_cnt), 32'd9);
    check("sw_not_stable", 32'(clk_stable), 32'd0);
    run_to(10);
    check("stable_e10", 32'(clk_stable), 32'd1);
    check("unlocked_e10", 32'(state), 32'(UNLOCKED));
    check("cnt_e10", 32'(lock_cnt), 32'd0);
    run_to(19);
    check("unlocked_e19", 32'(state), 32'(UNLOCKED));
    check("not_locked_e19", 32'(dll_locked), 32'd0);

    rst_pulse_at(20);
    check("locking_e20", 32'(state), 32'(LOCKING));
    check("cnt_e20", 32'(lock_cnt), 32'd0);
    run_to(21);
    check("cnt_e21", 32'(lock_cnt), 32'd1);
    run_to(399);
    check("cnt_e399", 32'(lock_cnt), 32'd379);
    rst_pulse_at(400);
    check("restart_cnt", 32'(lock_cnt), 32'd0);
    check("restart_state", 32'(state), 32'(LOCKING));
    run_to(1167);
    check("cnt_e1167", 32'(lock_cnt), 32'd767);
    check("not_locked_e1167", 32'(dll_locked), 32'd0);
    run_to(1168);
    check("locked_e1168", 32'(dll_locked), 32'd1);
    check("state_e1168", 32'(state), 32'(LOCKED));
    check("cnt_held_e1168", 32'(lock_cnt), 32'd0);
    run_to(1180);
    check("cnt_held_e1180", 32'(lock_cnt), 32'd0);

    rw_cmd = 1'b1;
    tick();
    rw_cmd = 1'b0;
    check("rw_locked_ok", 32'(early_access_err), 32'd0);

    dll_en = 1'b0;
    tick();
    check("dll_off_state", 32'(state), 32'(DLL_OFF));
    check("dll_off_unlocked", 32'(dll_locked), 32'd0);
    rw_cmd = 1'b1;
    tick();
    rw_cmd = 1'b0;
    check("rw_dll_off_ok", 32'(early_access_err), 32'd0);
    dll_en = 1'b1;
    tick();
    check("off_to_unlocked", 32'(state), 32'(UNLOCKED));

    cke    = 1'b0;
    rw_cmd = 1'b1;
    tick();
    rw_cmd = 1'b0;
    cke    = 1'b1;
    check("rw_cke_low_ok", 32'(early_access_err), 32'd0);

    dll_en  = 1'b0;
    dll_rst = 1'b1;
    tick();
    check("unl_dis_beats_rst", 32'(state), 32'(DLL_OFF));
    dll_en = 1'b1;
    tick();
    dll_rst = 1'b0;
    check("off_rst_locking", 32'(state), 32'(LOCKING));
    check("off_rst_cnt", 32'(lock_cnt), 32'd0);
    tick();
    check("off_rst_cnt1", 32'(lock_cnt), 32'd1);
    dll_en  = 1'b0;
    dll_rst = 1'b1;
    tick();
    dll_rst = 1'b0;
    dll_en  = 1'b1;
    check("lck_dis_beats_rst", 32'(state), 32'(DLL_OFF));

    // ---- Scenario 2: ignored early dll_rst, error on lock edge, relock, reset ----
    do_reset();
    rst_pulse_at(5);
    check("sw_rst_ignored", 32'(state), 32'(STABLE_WAIT));
    check("sw_rst_cnt5", 32'(lock_cnt), 32'd5);
    run_to(10);
    check("stable_again", 32'(clk_stable), 32'd1);
    rst_pulse_at(20);
    run_to(787);
    check("cnt_e787", 32'(lock_cnt), 32'd767);
    check("err_clear_e787", 32'(early_access_err), 32'd0);
    rw_cmd = 1'b1;
    tick();
    rw_cmd = 1'b0;
    check("locked_e788", 32'(dll_locked), 32'd1);
    check("err_on_lock_edge", 32'(early_access_err), 32'd1);
    run_to(800);
    check("err_sticky", 32'(early_access_err), 32'd1);

    cke = 1'b0;
    tick_n(4);
    cke = 1'b1;
    tick();
    check("cke4_stays_locked", 32'(state), 32'(LOCKED));
    cke = 1'b0;
    tick_n(5);
`ifdef DLL_SR_RELOCK_EN
    check("sr_entry_state", 32'(state), 32'(SELF_REFRESH));
    check("sr_unlocked", 32'(dll_locked), 32'd0);
    cke = 1'b1;
    tick();
    check("sr_exit_locking", 32'(state), 32'(LOCKING));
    check("sr_exit_cnt", 32'(lock_cnt), 32'd0);
    tick_n(767);
    check("sr_relock_cnt", 32'(lock_cnt), 32'd767);
    check("sr_relock_pending", 32'(dll_locked), 32'd0);
    tick();
    check("sr_relocked", 32'(dll_locked), 32'd1);
`else
    check("cke5_stays_locked", 32'(state), 32'(LOCKED));
    check("cke5_still_locked", 32'(dll_locked), 32'd1);
    cke = 1'b1;
    tick();
`endif

    dll_rst = 1'b1;
    tick();
    dll_rst = 1'b0;
    check("relock_state", 32'(state), 32'(LOCKING));
    check("relock_drop", 32'(dll_locked), 32'd0);
    check("relock_cnt0", 32'(lock_cnt), 32'd0);
    tick_n(5);
    check("relock_cnt5", 32'(lock_cnt), 32'd5);

    reset_n = 1'b0;
    tick();
    check_all_zero("midlock_reset");
    reset_n = 1'b1;
    tick();
    check("post_reset_sw", 32'(state), 32'(STABLE_WAIT));
    check("post_reset_stable", 32'(clk_stable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
